// File: rtl/tdc_ctrl_if.sv
// Host / delay-line signal bundle for the TDC measurement controller.
// master = host and delay-line side, slave = tdc_ctrl.
interface tdc_ctrl_if #(
    parameter int unsigned N_DELAY  = 32,
    parameter int unsigned PW_W     = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned CNT_W    = 6
);
    logic                         meas_req;
    logic [PW_W-1:0]              pulse_cycles;
    logic [PW_W-1:0]              settle_cycles;
    logic                         busy;
    logic                         tdc_start;
    logic [N_DELAY-1:0]           time_count;
    logic [CNT_W+AVG_LOG2-1:0]    meas_sum;
    logic                         meas_valid;
    logic                         ovf;
    logic                         unf;
    logic                         bubble_err;

    modport master (
        output meas_req, pulse_cycles, settle_cycles, time_count,
        input  busy, tdc_start, meas_sum, meas_valid, ovf, unf, bubble_err
    );

    modport slave (
        input  meas_req, pulse_cycles, settle_cycles, time_count,
        output busy, tdc_start, meas_sum, meas_valid, ovf, unf, bubble_err
    );
endinterface

// File: rtl/tdc_ctrl.sv
// TDC measurement controller: fires start pulses into the delay line, samples and
// popcount-decodes the thermometer code, and sums 2^AVG_LOG2 shots. Optional macro:
// TDC_THERMO_CHECK_EN enables the non-monotonic code (bubble) detector.
module tdc_ctrl #(
    parameter int unsigned N_DELAY  = 32,
    parameter int unsigned PW_W     = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned CNT_W    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    tdc_ctrl_if.slave  io_tdc
);
    localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
    localparam int unsigned CW     = PW_W + 1;
    localparam int unsigned SHOT_W = AVG_LOG2 + 1;
    localparam int unsigned SHOTS  = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_PULSE, S_SETTLE, S_SAMPLE, S_RECOVER, S_DONE
    } state_t;

    state_t             r_state;
    logic [PW_W-1:0]    r_pw;
    logic [PW_W-1:0]    r_st;
    logic [CW-1:0]      r_cnt;
    logic [SHOT_W-1:0]  r_shot;
    logic [N_DELAY-1:0] r_code;
    logic               r_code_vld;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   r_sum;
    logic               r_busy;
    logic               r_start;
    logic               r_valid;
    logic               r_ovf;
    logic               r_unf;

    logic [PW_W-1:0]    w_pw_in;
    logic [PW_W-1:0]    w_st_in;
    logic [CNT_W-1:0]   w_pop;
    logic               w_accept;

    // Zero widths behave as one cycle.
    assign w_pw_in  = (io_tdc.pulse_cycles  == '0) ? PW_W'(1) : io_tdc.pulse_cycles;
    assign w_st_in  = (io_tdc.settle_cycles == '0) ? PW_W'(1) : io_tdc.settle_cycles;
    assign w_accept = (r_state == S_IDLE) && io_tdc.meas_req;

    // Popcount of the sampled code; tolerant of bubbles in the thermometer.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(N_DELAY); i++) begin
            w_pop = w_pop + CNT_W'(r_code[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pw       <= '0;
            r_st       <= '0;
            r_cnt      <= '0;
            r_shot     <= '0;
            r_code     <= '0;
            r_code_vld <= 1'b0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_code_vld <= 1'b0;

            // Decode stage: one cycle after SAMPLE, always inside RECOVER.
            if (r_code_vld) begin
                r_acc <= r_acc + SUM_W'(w_pop);
                if (w_pop == '0)                r_unf <= 1'b1;
                if (w_pop == CNT_W'(N_DELAY))   r_ovf <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (io_tdc.meas_req) begin
                        r_state <= S_PULSE;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                        r_pw    <= w_pw_in;
                        r_st    <= w_st_in;
                        r_cnt   <= CW'(w_pw_in) - CW'(1);
                        r_shot  <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SETTLE;
                        r_start <= 1'b0;
                        r_cnt   <= CW'(r_st) - CW'(1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    r_code     <= io_tdc.time_count;
                    r_code_vld <= 1'b1;
                    r_shot     <= r_shot + SHOT_W'(1);
                    r_state    <= S_RECOVER;
                    r_cnt      <= CW'(r_pw) + CW'(r_st) - CW'(1);
                end
                S_RECOVER: begin
                    if (r_cnt == '0) begin
                        if (r_shot < SHOT_W'(SHOTS)) begin
                            r_state <= S_PULSE;
                            r_start <= 1'b1;
                            r_cnt   <= CW'(r_pw) - CW'(1);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    r_sum   <= r_acc;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TDC_THERMO_CHECK_EN
    logic r_bubble;
    logic w_bubble;

    // A 1 directly above a 0 anywhere means the code is not 0..01..1.
    assign w_bubble = |(r_code[N_DELAY-1:1] & ~r_code[N_DELAY-2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble <= 1'b0;
        end else if (w_accept) begin
            r_bubble <= 1'b0;
        end else if (r_code_vld && w_bubble) begin
            r_bubble <= 1'b1;
        end
    end

    assign io_tdc.bubble_err = r_bubble;
`else
    logic w_unused_accept;
    assign w_unused_accept   = w_accept;
    assign io_tdc.bubble_err = 1'b0;
`endif

    assign io_tdc.busy       = r_busy;
    assign io_tdc.tdc_start  = r_start;
    assign io_tdc.meas_sum   = r_sum;
    assign io_tdc.meas_valid = r_valid;
    assign io_tdc.ovf        = r_ovf;
    assign io_tdc.unf        = r_unf;
endmodule

// File: tb/tb_tdc_ctrl.sv
// Self-checking bench for tdc_ctrl: delay-line model, schedule-based reference model,
// per-cycle compare process, directed cases plus randomized measurements.
module tb_tdc_ctrl;
    localparam int unsigned N_DELAY  = 32;
    localparam int unsigned PW_W     = 8;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned SUM_W    = CNT_W + AVG_LOG2;
    localparam int          SHOTS    = 1 << AVG_LOG2;
`ifdef TDC_THERMO_CHECK_EN
    localparam bit BUB_EN = 1'b1;
`else
    localparam bit BUB_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tdc_ctrl_if #(.N_DELAY(N_DELAY), .PW_W(PW_W), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W)) bus ();

    tdc_ctrl #(.N_DELAY(N_DELAY), .PW_W(PW_W), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_tdc (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Delay line: garbage while the start pulse is high, the captured code afterwards.
    logic [N_DELAY-1:0] line_code = '0;
    logic [N_DELAY-1:0] junk      = '0;
    assign bus.time_count = bus.tdc_start ? junk : line_code;
    always @(negedge clk) junk = N_DELAY'($urandom);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N_DELAY-1:0] therm(input int k);
        if (k <= 0) return '0;
        if (k >= int'(N_DELAY)) return '1;
        return N_DELAY'((64'd1 << k) - 64'd1);
    endfunction

    // Reference model: a measurement accepted at edge n occupies edges n .. n+SHOTS*T,
    // strobes at n+SHOTS*T+1, with pulses at the start of each T = 2P+2S+1 slot.
    bit               m_active = 1'b0;
    bit               m_valid  = 1'b0;
    int               m_n = 0, m_p = 1, m_s = 1, m_t = 1, m_end = 0, m_c = 0;
    logic [SUM_W-1:0] m_sum = '0, p_sum = '0;
    bit               m_ovf = 0, m_unf = 0, m_bub = 0, p_ovf = 0, p_unf = 0, p_bub = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_sum    = '0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_bub    = 1'b0;
        end else begin
            cyc++;
            m_valid = 1'b0;
            if (m_active && cyc == m_end) begin
                m_active = 1'b0;
                m_valid  = 1'b1;
                m_sum    = p_sum;
                m_ovf    = p_ovf;
                m_unf    = p_unf;
                m_bub    = p_bub;
            end else if (!m_active && bus.meas_req) begin
                m_active = 1'b1;
                m_n      = cyc;
                m_p      = (bus.pulse_cycles == '0)  ? 1 : int'(bus.pulse_cycles);
                m_s      = (bus.settle_cycles == '0) ? 1 : int'(bus.settle_cycles);
                m_t      = 2 * m_p + 2 * m_s + 1;
                m_end    = cyc + SHOTS * m_t + 1;
                m_c      = $countones(line_code);
                p_sum    = SUM_W'(SHOTS * m_c);
                p_unf    = (m_c == 0);
                p_ovf    = (m_c == int'(N_DELAY));
                p_bub    = BUB_EN && ((line_code & (line_code + N_DELAY'(1))) != '0);
            end
        end
    end

    // Per-cycle compare against the model.
    int  d;
    bit  e_start;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_tdc_start", bus.tdc_start, 0);
            chk("rst_meas_valid", bus.meas_valid, 0);
            chk("rst_meas_sum", bus.meas_sum, 0);
            chk("rst_flags", {bus.ovf, bus.unf, bus.bubble_err}, 0);
        end else begin
            d       = cyc - m_n;
            e_start = m_active && (d < SHOTS * m_t) && ((d % m_t) < m_p);
            chk("busy", bus.busy, m_active);
            chk("tdc_start", bus.tdc_start, e_start);
            chk("meas_valid", bus.meas_valid, m_valid);
            chk("meas_sum", bus.meas_sum, m_sum);
            if (!m_active) begin
                chk("ovf", bus.ovf, m_ovf);
                chk("unf", bus.unf, m_unf);
                chk("bubble_err", bus.bubble_err, m_bub);
            end
        end
    end

    int n_rise = 0, n_high = 0, n_valid = 0;
    bit prev_start = 1'b0;
    always @(negedge clk) begin
        if (bus.tdc_start) n_high++;
        if (bus.tdc_start && !prev_start) n_rise++;
        prev_start = bus.tdc_start;
        if (bus.meas_valid) n_valid++;
    end

    task automatic run_meas(input int p, input int s, input logic [N_DELAY-1:0] code, input bit poke,
                            output int lat, output int pulses, output int hi, output int valids,
                            output logic [SUM_W-1:0] sum, output logic [3:0] flg);
        int t0, r0, h0, v0;
        bit seen;
        line_code         = code;
        bus.pulse_cycles  = PW_W'(p);
        bus.settle_cycles = PW_W'(s);
        bus.meas_req      = 1'b1;
        t0 = cyc; r0 = n_rise; h0 = n_high; v0 = n_valid;
        seen = 1'b0; lat = -1; sum = '0; flg = '0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            bus.meas_req = poke && (i == 3 || i == 9);
            if (bus.meas_valid) begin
                seen = 1'b1;
                lat  = cyc - t0;
                sum  = bus.meas_sum;
                flg  = {bus.busy, bus.ovf, bus.unf, bus.bubble_err};
            end
        end
        bus.meas_req = 1'b0;
        if (!seen) chk("meas_valid_timeout", 0, 1);
        @(negedge clk);
        pulses = n_rise - r0;
        hi     = n_high - h0;
        valids = n_valid - v0;
    endtask

    task automatic rand_meas();
        int p, s, mode, hold;
        logic [N_DELAY-1:0] code;
        bit seen;
        p    = $urandom_range(0, 5);
        s    = $urandom_range(0, 5);
        mode = $urandom_range(0, 4);
        case (mode)
            0:       code = therm(3 * p);
            1:       code = '0;
            2:       code = '1;
            3:       code = therm($urandom_range(0, N_DELAY));
            default: code = N_DELAY'($urandom);
        endcase
        hold              = $urandom_range(1, 3);
        line_code         = code;
        bus.pulse_cycles  = PW_W'(p);
        bus.settle_cycles = PW_W'(s);
        bus.meas_req      = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (bus.meas_valid) seen = 1'b1;
            bus.meas_req = !seen && ((i < hold - 1) || ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 7) == 0) begin
                bus.pulse_cycles  = PW_W'($urandom_range(0, 5));
                bus.settle_cycles = PW_W'($urandom_range(0, 5));
            end
        end
        bus.meas_req = 1'b0;
        if (!seen) chk("rand_meas_valid_timeout", 0, 1);
        @(negedge clk);
    endtask

    int               lat, pulses, hi, valids, rises, c1, c2;
    logic [SUM_W-1:0] sum;
    logic [3:0]       flg;
    bit               lprev, seen2;

    initial begin
        bus.meas_req      = 1'b0;
        bus.pulse_cycles  = '0;
        bus.settle_cycles = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.tdc_start, bus.meas_valid, bus.ovf, bus.unf, bus.bubble_err}, 0);
        chk("reset_meas_sum", bus.meas_sum, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Line model, pulse=4 settle=2: k=12 per shot.
        run_meas(4, 2, therm(12), 1'b0, lat, pulses, hi, valids, sum, flg);
        chk("line_sum", sum, 48);
        chk("line_model_sum", m_sum, 48);
        chk("line_pulses", pulses, 4);
        chk("line_pulse_cycles", hi, 16);
        chk("line_latency", lat, 54);
        chk("line_valids", valids, 1);
        chk("line_busy_at_valid", flg[3], 0);
        chk("line_ovf_unf", flg[2:1], 0);

        run_meas(4, 2, '0, 1'b0, lat, pulses, hi, valids, sum, flg);
        chk("zero_sum", sum, 0);
        chk("zero_unf", flg[1], 1);
        chk("zero_ovf", flg[2], 0);

        run_meas(4, 2, '1, 1'b0, lat, pulses, hi, valids, sum, flg);
        chk("ones_sum", sum, 128);
        chk("ones_ovf", flg[2], 1);
        chk("ones_unf", flg[1], 0);

        run_meas(0, 0, therm(3), 1'b0, lat, pulses, hi, valids, sum, flg);
        chk("min_latency", lat, 22);
        chk("min_pulse_cycles", hi, 4);
        chk("min_pulses", pulses, 4);
        chk("min_sum", sum, 12);

        // Async reset during the second shot's pulse.
        line_code         = therm(12);
        bus.pulse_cycles  = PW_W'(4);
        bus.settle_cycles = PW_W'(2);
        bus.meas_req      = 1'b1;
        rises = 0; lprev = 1'b0;
        for (int i = 0; i < 500 && rises < 2; i++) begin
            @(negedge clk);
            bus.meas_req = 1'b0;
            if (bus.tdc_start && !lprev) rises++;
            lprev = bus.tdc_start;
        end
        if (rises < 2) chk("shot2_timeout", 0, 1);
        @(posedge clk);
        #2;
        chk("pre_rst_tdc_start", bus.tdc_start, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tdc_start", bus.tdc_start, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_meas_valid", bus.meas_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_meas(4, 2, therm(12), 1'b0, lat, pulses, hi, valids, sum, flg);
        chk("post_rst_sum", sum, 48);
        chk("post_rst_valids", valids, 1);

        run_meas(1, 1, N_DELAY'(32'h0000_000B), 1'b0, lat, pulses, hi, valids, sum, flg);
        chk("bubble_sum", sum, 12);
        chk("bubble_err", flg[0], BUB_EN);

        run_meas(2, 3, therm(7), 1'b1, lat, pulses, hi, valids, sum, flg);
        chk("poke_valids", valids, 1);
        chk("poke_sum", sum, 28);
        chk("poke_pulses", pulses, 4);

        // meas_req held across the strobe: next measurement starts one cycle later.
        line_code         = therm(5);
        bus.pulse_cycles  = PW_W'(1);
        bus.settle_cycles = PW_W'(1);
        bus.meas_req      = 1'b1;
        c1 = -1; c2 = -1; seen2 = 1'b0;
        for (int i = 0; i < 500 && !seen2; i++) begin
            @(negedge clk);
            if (bus.meas_valid) begin
                if (c1 < 0) c1 = cyc;
                else begin c2 = cyc; seen2 = 1'b1; bus.meas_req = 1'b0; end
            end
        end
        bus.meas_req = 1'b0;
        chk("b2b_gap", c2 - c1, 22);
        @(negedge clk);

        for (int it = 0; it < 40; it++) rand_meas();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tdc_ctrl.md
Name: tdc_ctrl

Overview:
- Measurement controller that drives the TDC delay line from the other end.
- Generates the start pulse into the delay line and waits for the line to capture on the pulse's falling edge.
- Samples the captured thermometer code, decodes it to a binary stage count, and averages over a programmable number of shots.
- Sits between the register/host interface and the delay-line macro.

Parameters:
- N_DELAY, 32, number of thermometer bits from the delay line. Must match the line.
- PW_W, 8, width of the pulse-width and settle/recover counters.
- AVG_LOG2, 2, log2 of the number of shots accumulated per measurement (1..8).
- CNT_W, 6, width of the decoded count, ceil(log2(N_DELAY+1)).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- meas_req  input  1  start a measurement; sampled in IDLE only.
- pulse_cycles  input  PW_W  start-pulse high time in clk cycles; 0 is treated as 1.
- settle_cycles  input  PW_W  wait after falling edge before sampling; 0 is treated as 1.
- busy  output  1  high from acceptance of meas_req until done.
- tdc_start  output  1  registered start pulse to the delay line.
- time_count  input  N_DELAY  captured thermometer code from the delay line; LSB is the first stage.
- meas_sum  output  CNT_W+AVG_LOG2  sum of decoded counts over 2^AVG_LOG2 shots.
- meas_valid  output  1  one-cycle strobe when meas_sum updates.
- ovf  output  1  sticky for the measurement: some shot decoded all-ones (N_DELAY).
- unf  output  1  sticky for the measurement: some shot decoded zero.
- bubble_err  output  1  sticky for the measurement: a non-monotonic code was seen (optional feature).

Behaviour:
- Reset values: busy=0, tdc_start=0, meas_sum=0, meas_valid=0, ovf=0, unf=0, bubble_err=0, state=IDLE, all counters 0.
- Reset asserted mid-operation clears everything immediately, including tdc_start (forced low).
- State machine states: IDLE, PULSE, SETTLE, SAMPLE, RECOVER, DONE.
- IDLE:
  - meas_req=1 moves to PULSE on the next edge, and busy=1 in the same edge.
  - The shot counter, accumulator and sticky flags clear on acceptance.
- PULSE:
  - tdc_start=1 for exactly max(pulse_cycles,1) cycles.
  - The counter loads on entry; pulse_cycles is latched at acceptance and held for the whole measurement.
  - tdc_start drops on the edge entering SETTLE.
- SETTLE:
  - Waits max(settle_cycles,1) cycles, with settle_cycles latched at acceptance.
  - The code is static after the falling edge, so no synchronizer is used; the settle wait is the metastability guard.
- SAMPLE:
  - One cycle; registers time_count into the decode stage.
- Decode (1-cycle registered pipeline stage):
  - count = popcount(time_count), 0..N_DELAY.
  - The popcount makes the result bubble-tolerant.
  - unf is set if count==0; ovf is set if count==N_DELAY.
  - The accumulator adds count, zero-extended.
- RECOVER:
  - Waits max(pulse_cycles,1)+max(settle_cycles,1) cycles so the low level has flushed the line.
  - Then, if shots done < 2^AVG_LOG2, goes to PULSE; otherwise goes to DONE.
- DONE:
  - meas_sum is loaded from the accumulator, meas_valid=1 for one cycle, busy=0 on the same edge, then IDLE.
  - meas_sum and the flags hold until the next acceptance.
- Accumulator width CNT_W+AVG_LOG2 cannot overflow. Maximum is N_DELAY<<AVG_LOG2.
- meas_req while busy is ignored; no queuing.
- meas_req held high in IDLE after DONE starts a new measurement one cycle after the meas_valid strobe.
- Latency, with P=max(pulse,1) and S=max(settle,1):
  - per shot = P+S+1+(P+S).
  - total = 1 + shots×(2P+2S+1) + 1 cycles from meas_req to meas_valid.

Optional Feature:
- Macro: TDC_THERMO_CHECK_EN.
- Defined: in the decode stage, bubble_err is set if any bit i=1 while a lower bit j<i is 0, i.e. the code is not of the form 0…01…1. Detection uses a per-bit check (time_count[i] & ~time_count[i-1]) ORed across bits.
- Not defined: bubble_err is tied 0 and no check logic is synthesized.
- The popcount result is identical in both builds.

Test Plan:
- Bench line model (time_count = (1<<k)-1, k=3×pulse_cycles clamped), AVG_LOG2=2, pulse=4, settle=2, meas_req -> 4 tdc_start pulses of 4 cycles; meas_valid once with meas_sum=48; ovf=unf=0; busy falls with meas_valid.
- Model forced to 0x00000000 -> meas_sum=0, unf=1, ovf=0.
- Model forced to 0xFFFFFFFF -> meas_sum=128, ovf=1.
- pulse_cycles=0, settle_cycles=0 -> tdc_start high exactly 1 cycle per shot; total latency 1+4×5+1=22 cycles.
- rst_n asserted during PULSE, shot 2 -> tdc_start=0 and busy=0 asynchronously; no meas_valid; a fresh meas_req afterwards gives a correct full result.
- With TDC_THERMO_CHECK_EN, model returns 0x0000000B -> count 3 per shot, meas_sum=12, bubble_err=1. Without the macro -> bubble_err=0, meas_sum=12.
- meas_req pulsed during busy -> ignored; exactly one meas_valid.
